// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory handshake, watchdog and retire counter
module mips_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             byte_op,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [3:0]       state,
  output logic             halted,
  output logic [1:0]       error_code,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_WB_ALU   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;

  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

  logic [3:0]       state_q, state_d;
  logic [1:0]       error_q, error_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       retire;
  logic       counting;
  logic       wait_full;
  logic       is_jr;
  logic       pc_write_c, ir_write_c, iord_c, mem_read_c, mem_write_c, byte_op_c, reg_write_c, alu_src_a_c;
  logic [1:0] pc_src_c, reg_dst_c, mem_to_reg_c, alu_src_b_c;
  logic [2:0] alu_op_c;

  assign is_jr     = (opcode == OP_RTYPE) && (funct == FN_JR);
  // Limit cycle: this is the WAIT_LIMIT-th consecutive low cycle.
  assign wait_full = (wait_q == WAIT_W'(WAIT_LIMIT - 1));
  assign counting  = ((state_q == S_FETCH) && run) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  always_comb begin
    state_d      = state_q;
    error_d      = error_q;
    retire       = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 2'd0;
    ir_write_c   = 1'b0;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    byte_op_c    = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 2'd0;
    mem_to_reg_c = 2'd0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'd0;
    alu_op_c     = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = run;
        alu_src_b_c = 2'd1;
        if (run && mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (run && wait_full) begin
          state_d = S_HALT;
          error_d = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        alu_src_b_c = 2'd3;
        case (opcode)
          OP_RTYPE:                    state_d = is_jr ? S_JUMP : S_EXEC_R;
          OP_ADDI:                     state_d = S_EXEC_I;
          OP_LW, OP_SW, OP_LB, OP_SB:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:              state_d = S_BRANCH;
          OP_J, OP_JAL:                state_d = S_JUMP;
          default: begin
            state_d = S_HALT;
            error_d = ERR_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALU_FUNCT;
        state_d     = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        state_d     = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write_c = 1'b1;
        reg_dst_c   = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        state_d     = ((opcode == OP_SW) || (opcode == OP_SB)) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord_c     = 1'b1;
        mem_read_c = 1'b1;
        byte_op_c  = (opcode == OP_LB);
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (wait_full) begin
          state_d = S_HALT;
          error_d = ERR_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
        byte_op_c   = (opcode == OP_SB);
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (wait_full) begin
          state_d = S_HALT;
          error_d = ERR_TIMEOUT;
        end
      end
      S_WB_MEM: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 2'd1;
        byte_op_c    = (opcode == OP_LB);
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALU_SUB;
        pc_src_c    = 2'd1;
        pc_write_c  = zero ^ opcode[0];
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src_c   = is_jr ? 2'd3 : 2'd2;
        if (opcode == OP_JAL) begin
          reg_write_c  = 1'b1;
          reg_dst_c    = 2'd2;
          mem_to_reg_c = 2'd2;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // The counter is frozen outside its counting states (including FETCH with run low).
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (counting) begin
      wait_d = mem_ready ? '0 : wait_q + WAIT_W'(1);
    end
  end

  assign count_d = retire ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      error_q <= 2'd0;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  // Gating with reset_n kills every strobe the instant reset asserts, mid-instruction included.
  assign pc_write    = reset_n & pc_write_c;
  assign pc_src      = reset_n ? pc_src_c : 2'd0;
  assign ir_write    = reset_n & ir_write_c;
  assign iord        = reset_n & iord_c;
  assign mem_read    = reset_n & mem_read_c;
  assign mem_write   = reset_n & mem_write_c;
  assign byte_op     = reset_n & byte_op_c;
  assign reg_write   = reset_n & reg_write_c;
  assign reg_dst     = reset_n ? reg_dst_c : 2'd0;
  assign mem_to_reg  = reset_n ? mem_to_reg_c : 2'd0;
  assign alu_src_a   = reset_n & alu_src_a_c;
  assign alu_src_b   = reset_n ? alu_src_b_c : 2'd0;
  assign alu_op      = reset_n ? alu_op_c : 3'd0;
  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign error_code  = error_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       byte_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } ctl_t;

  typedef struct packed {
    logic [3:0]  st;
    ctl_t        c;
    logic        halted;
    logic [1:0]  err;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [5:0] OP_R = 6'h00, LW = 6'h23, SW = 6'h2B, LB = 6'h20, SB = 6'h28;
  localparam logic [5:0] ADDI = 6'h08, BEQ = 6'h04, BNE = 6'h05, JAL = 6'h03, BAD = 6'h3F;
  localparam logic [5:0] FN_ADD = 6'h20, FN_JR = 6'h08;
  localparam logic [3:0] FE = 4'd0, DE = 4'd1, XR = 4'd2, XI = 4'd3, WA = 4'd4, MA = 4'd5;
  localparam logic [3:0] MR = 4'd6, MW = 4'd7, WM = 4'd8, BR = 4'd9, JU = 4'd10, HA = 4'd11;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, iord, mem_read, mem_write, byte_op, reg_write, alu_src_a, halted;
  logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b, error_code;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;
  ctl_t        obs_ctl;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [1:0]  exp_err = 2'd0;
  exp_t        sb_q[$];
  string       tag_q[$];

  mips_multicycle_ctrl #(.WAIT_LIMIT(15), .CNT_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .byte_op(byte_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
    .halted(halted), .error_code(error_code), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  assign obs_ctl = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, byte_op,
                    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op};

  function automatic ctl_t c_none();
    return '0;
  endfunction
  function automatic ctl_t c_fetch(input logic r, input logic y);
    ctl_t c = '0;
    c.mem_read = r; c.alu_src_b = 2'd1; c.ir_write = r & y; c.pc_write = r & y;
    return c;
  endfunction
  function automatic ctl_t c_decode();
    ctl_t c = '0;
    c.alu_src_b = 2'd3;
    return c;
  endfunction
  function automatic ctl_t c_exec_r();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 3'd2;
    return c;
  endfunction
  function automatic ctl_t c_imm();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
    return c;
  endfunction
  function automatic ctl_t c_wb_alu(input logic rtype);
    ctl_t c = '0;
    c.reg_write = 1'b1; c.reg_dst = rtype ? 2'd1 : 2'd0;
    return c;
  endfunction
  function automatic ctl_t c_mem_rd(input logic b);
    ctl_t c = '0;
    c.iord = 1'b1; c.mem_read = 1'b1; c.byte_op = b;
    return c;
  endfunction
  function automatic ctl_t c_mem_wr(input logic b);
    ctl_t c = '0;
    c.iord = 1'b1; c.mem_write = 1'b1; c.byte_op = b;
    return c;
  endfunction
  function automatic ctl_t c_wb_mem(input logic b);
    ctl_t c = '0;
    c.reg_write = 1'b1; c.mem_to_reg = 2'd1; c.byte_op = b;
    return c;
  endfunction
  function automatic ctl_t c_branch(input logic taken);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 3'd1; c.pc_src = 2'd1; c.pc_write = taken;
    return c;
  endfunction
  function automatic ctl_t c_jump(input logic jr, input logic link);
    ctl_t c = '0;
    c.pc_write = 1'b1; c.pc_src = jr ? 2'd3 : 2'd2;
    if (link) begin
      c.reg_write = 1'b1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare at the falling edge.
  task automatic step(input string tag, input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic y, input logic [3:0] st, input ctl_t c, input logic ret);
    exp_t  e;
    string t;
    run = r; opcode = op; funct = fn; zero = z; mem_ready = y;
    e.st = st; e.c = c; e.halted = (st == HA); e.err = exp_err; e.cnt = exp_cnt;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clock);
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ":state"}, 64'(state), 64'(e.st));
    chk({t, ":ctl"}, 64'(obs_ctl), 64'(e.c));
    chk({t, ":status"}, 64'({halted, error_code, instr_count}), 64'({e.halted, e.err, e.cnt}));
    @(posedge clock);
    #1;
    if (ret) exp_cnt++;
  endtask

  initial begin
    logic       rr, yy, zz;
    logic [5:0] oo;

    step("rst_hold", 1, OP_R, FN_ADD, 0, 1, FE, c_none(), 0);
    step("rst_hold", 1, OP_R, FN_ADD, 0, 1, FE, c_none(), 0);
    reset_n = 1'b1;

    step("r_fetch", 1, OP_R, FN_ADD, 0, 1, FE, c_fetch(1, 1), 0);
    step("r_dec",   1, OP_R, FN_ADD, 0, 1, DE, c_decode(), 0);
    step("r_exec",  1, OP_R, FN_ADD, 0, 1, XR, c_exec_r(), 0);
    step("r_wb",    1, OP_R, FN_ADD, 0, 1, WA, c_wb_alu(1), 1);

    step("addi_fetch", 1, ADDI, 6'h00, 0, 1, FE, c_fetch(1, 1), 0);
    step("addi_dec",   1, ADDI, 6'h00, 0, 1, DE, c_decode(), 0);
    step("addi_exec",  1, ADDI, 6'h00, 0, 1, XI, c_imm(), 0);
    step("addi_wb",    1, ADDI, 6'h00, 0, 1, WA, c_wb_alu(0), 1);

    step("lw_fetch", 1, LW, 6'h00, 0, 1, FE, c_fetch(1, 1), 0);
    step("lw_dec",   1, LW, 6'h00, 0, 1, DE, c_decode(), 0);
    step("lw_addr",  1, LW, 6'h00, 0, 1, MA, c_imm(), 0);
    for (int i = 0; i < 3; i++) step("lw_wait", 1, LW, 6'h00, 0, 0, MR, c_mem_rd(0), 0);
    step("lw_rd",    1, LW, 6'h00, 0, 1, MR, c_mem_rd(0), 0);
    step("lw_wb",    1, LW, 6'h00, 0, 1, WM, c_wb_mem(0), 1);

    step("lb_fetch", 1, LB, 6'h00, 0, 1, FE, c_fetch(1, 1), 0);
    step("lb_dec",   1, LB, 6'h00, 0, 1, DE, c_decode(), 0);
    step("lb_addr",  1, LB, 6'h00, 0, 1, MA, c_imm(), 0);
    step("lb_rd",    1, LB, 6'h00, 0, 1, MR, c_mem_rd(1), 0);
    step("lb_wb",    1, LB, 6'h00, 0, 1, WM, c_wb_mem(1), 1);

    step("beq_fetch", 1, BEQ, 6'h00, 1, 1, FE, c_fetch(1, 1), 0);
    step("beq_dec",   1, BEQ, 6'h00, 1, 1, DE, c_decode(), 0);
    step("beq_z1",    1, BEQ, 6'h00, 1, 1, BR, c_branch(1), 1);
    step("bne_fetch", 1, BNE, 6'h00, 1, 1, FE, c_fetch(1, 1), 0);
    step("bne_dec",   1, BNE, 6'h00, 1, 1, DE, c_decode(), 0);
    step("bne_z1",    1, BNE, 6'h00, 1, 1, BR, c_branch(0), 1);
    step("bne_fetch", 1, BNE, 6'h00, 0, 1, FE, c_fetch(1, 1), 0);
    step("bne_dec",   1, BNE, 6'h00, 0, 1, DE, c_decode(), 0);
    step("bne_z0",    1, BNE, 6'h00, 0, 1, BR, c_branch(1), 1);

    step("jal_fetch", 1, JAL, 6'h00, 0, 1, FE, c_fetch(1, 1), 0);
    step("jal_dec",   1, JAL, 6'h00, 0, 1, DE, c_decode(), 0);
    step("jal_jump",  1, JAL, 6'h00, 0, 1, JU, c_jump(0, 1), 1);
    step("jr_fetch",  1, OP_R, FN_JR, 0, 1, FE, c_fetch(1, 1), 0);
    step("jr_dec",    1, OP_R, FN_JR, 0, 1, DE, c_decode(), 0);
    step("jr_jump",   1, OP_R, FN_JR, 0, 1, JU, c_jump(1, 0), 1);

    step("mid_fetch", 1, LW, 6'h00, 0, 1, FE, c_fetch(1, 1), 0);
    step("mid_dec",   1, LW, 6'h00, 0, 1, DE, c_decode(), 0);
    step("mid_addr",  1, LW, 6'h00, 0, 1, MA, c_imm(), 0);
    step("mid_wait",  1, LW, 6'h00, 0, 0, MR, c_mem_rd(0), 0);
    reset_n = 1'b0;
    exp_cnt = 32'd0;
    step("mid_reset", 1, LW, 6'h00, 0, 1, FE, c_none(), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) step("fetch_wait",  1, SW, 6'h00, 0, 0, FE, c_fetch(1, 0), 0);
    for (int i = 0; i < 10; i++) step("fetch_pause", 0, SW, 6'h00, 0, 0, FE, c_fetch(0, 0), 0);
    for (int i = 0; i < 4; i++)  step("fetch_wait2", 1, SW, 6'h00, 0, 0, FE, c_fetch(1, 0), 0);

    step("sw_fetch", 1, SW, 6'h00, 0, 1, FE, c_fetch(1, 1), 0);
    step("sw_dec",   1, SW, 6'h00, 0, 1, DE, c_decode(), 0);
    step("sw_addr",  1, SW, 6'h00, 0, 0, MA, c_imm(), 0);
    for (int i = 0; i < 14; i++) step("sw_wait", 1, SW, 6'h00, 0, 0, MW, c_mem_wr(0), 0);
    step("sw_limit_ready", 1, SW, 6'h00, 0, 1, MW, c_mem_wr(0), 1);

    step("sb_fetch", 1, SB, 6'h00, 0, 1, FE, c_fetch(1, 1), 0);
    step("sb_dec",   1, SB, 6'h00, 0, 1, DE, c_decode(), 0);
    step("sb_addr",  1, SB, 6'h00, 0, 0, MA, c_imm(), 0);
    for (int i = 0; i < 15; i++) step("sb_wait", 1, SB, 6'h00, 0, 0, MW, c_mem_wr(1), 0);
    exp_err = 2'd2;
    for (int i = 0; i < 3; i++) step("timeout_halt", 1, SB, 6'h00, 0, 1, HA, c_none(), 0);

    reset_n = 1'b0;
    exp_cnt = 32'd0;
    exp_err = 2'd0;
    step("rst_pulse", 1, BAD, 6'h00, 0, 0, FE, c_none(), 0);
    reset_n = 1'b1;

    step("bad_fetch", 1, BAD, 6'h00, 0, 1, FE, c_fetch(1, 1), 0);
    step("bad_dec",   1, BAD, 6'h00, 0, 1, DE, c_decode(), 0);
    exp_err = 2'd1;
    for (int i = 0; i < 20; i++) begin
      rr = 1'($urandom); yy = 1'($urandom); zz = 1'($urandom); oo = 6'($urandom);
      step("illegal_halt", rr, oo, 6'h08, zz, yy, HA, c_none(), 0);
    end

    reset_n = 1'b0;
    exp_cnt = 32'd0;
    exp_err = 2'd0;
    step("rst_pulse2", 1, OP_R, FN_ADD, 0, 1, FE, c_none(), 0);
    reset_n = 1'b1;
    step("post_fetch", 1, OP_R, FN_ADD, 0, 1, FE, c_fetch(1, 1), 0);
    step("post_dec",   1, OP_R, FN_ADD, 0, 1, DE, c_decode(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
